// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: definitions shared by the UART transmitter and receiver
// (frame state encoding, frame geometry and line idle level).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
`timescale 1ns/1ps
// uart_tx_if: producer-side byte handshake plus the serial line and status
// of one UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 serial_out;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  serial_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output serial_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// uart_bit_timer: counts system clocks within one serial bit and flags the
// last cycle of every bit period; clear parks the count at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);
    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    assign bit_end = (cnt_r == CNT_LAST);

    // Per-bit clock counter, wrapping at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (bit_end) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end
endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8N1 serial transmitter with a one-byte holding register so that a
// queued byte follows the previous stop bit with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    uart_state_e          state_r;
    uart_state_e          state_s;
    logic [DATA_BITS-1:0] hold_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 full_r;
    logic [2:0]           bit_idx_r;
    logic                 serial_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 accept_s;
    logic                 load_s;
    logic                 line_s;
    logic                 bit_end_s;
    logic                 timer_clr_s;

    assign accept_s    = bus.tx_valid && !full_r;
    assign timer_clr_s = (state_r == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clr_s),
        .bit_end(bit_end_s)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, holding-register load strobe and the line level of this state.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        line_s  = IDLE_LEVEL;
        case (state_r)
            IDLE: begin
                line_s = IDLE_LEVEL;
                if (full_r) begin
                    load_s  = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                line_s = ~IDLE_LEVEL;
                if (bit_end_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                line_s = shift_r[0];
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_s = STOP;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                line_s = IDLE_LEVEL;
                if (bit_end_s && full_r) begin
                    load_s  = 1'b1;
                    state_s = START;
                end else if (bit_end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                line_s  = IDLE_LEVEL;
                state_s = IDLE;
            end
        endcase
    end

    // Holding register; an accept wins over a load so a fresh byte stays queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= 8'h00;
            full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r <= bus.tx_data;
            full_r <= 1'b1;
        end else if (load_s) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    // Data shifter and data-bit index, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
        end else if (load_s) begin
            shift_r   <= hold_r;
            bit_idx_r <= 3'd0;
        end else if ((state_r == DATA) && bit_end_s) begin
            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Line, busy and done are all registered from the current state so they
    // stay cycle-aligned with each other, one clock behind the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_r <= IDLE_LEVEL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            serial_r <= line_s;
            busy_r   <= (state_r != IDLE);
            done_r   <= (state_r == STOP) && bit_end_s;
        end
    end

    assign bus.tx_ready   = ~full_r;
    assign bus.serial_out = serial_r;
    assign bus.tx_busy    = busy_r;
    assign bus.tx_done    = done_r;
endmodule
